// File: rtl/axis_read_data.sv
// AXI read data channel to stream converter.
// AXI read beats are buffered, split into DATA_WIDTH words (low word first)
// and framed into streams whose word counts come from a queued length FIFO.
module axis_read_data #(
    parameter int BUF_CFG_AWIDTH = 5,
    parameter int BUF_AWIDTH     = 9,
    parameter int CFG_DWIDTH     = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CFG_DWIDTH-1:0]     cfg_length,
    input  logic                      cfg_val,
    output logic                      cfg_rdy,
    input  logic [AXI_DATA_WIDTH-1:0] axi_rdata,
    input  logic                      axi_rlast,
    input  logic                      axi_rvalid,
    output logic                      axi_rready,
    output logic [DATA_WIDTH-1:0]     data,
    output logic                      valid,
    output logic                      last,
    input  logic                      ready
);

    localparam int R         = AXI_DATA_WIDTH / DATA_WIDTH;
    localparam int SUB_W     = (R > 1) ? $clog2(R) : 1;
    localparam int CFG_DEPTH = 1 << BUF_CFG_AWIDTH;
    localparam int BUF_DEPTH = 1 << BUF_AWIDTH;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(R - 1);

    typedef enum logic [2:0] {
        ST_CONFIG = 3'b001,
        ST_SET    = 3'b010,
        ST_ACTIVE = 3'b100
    } state_t;

    state_t state, state_nxt;

    // Framing is driven by the configured length, not by AXI burst boundaries.
    logic unused_rlast;
    assign unused_rlast = axi_rlast;

    // ---------------- length configuration FIFO ----------------
    logic [CFG_DWIDTH-1:0]   cfg_mem [CFG_DEPTH];
    logic [BUF_CFG_AWIDTH:0] cfg_wr_ptr, cfg_rd_ptr;
    logic                    cfg_empty, cfg_full, cfg_push, cfg_pop;
    logic [CFG_DWIDTH-1:0]   cfg_head;

    assign cfg_empty = (cfg_wr_ptr == cfg_rd_ptr);
    assign cfg_full  = (cfg_wr_ptr[BUF_CFG_AWIDTH] != cfg_rd_ptr[BUF_CFG_AWIDTH]) &&
                       (cfg_wr_ptr[BUF_CFG_AWIDTH-1:0] == cfg_rd_ptr[BUF_CFG_AWIDTH-1:0]);
    assign cfg_rdy   = ~cfg_full;
    assign cfg_push  = cfg_val & ~cfg_full;
    assign cfg_head  = cfg_mem[cfg_rd_ptr[BUF_CFG_AWIDTH-1:0]];

    // Store accepted length words.
    always_ff @(posedge clk) begin
        if (cfg_push)
            cfg_mem[cfg_wr_ptr[BUF_CFG_AWIDTH-1:0]] <= cfg_length;
    end

    // Length FIFO pointers; reset empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_wr_ptr <= '0;
            cfg_rd_ptr <= '0;
        end else begin
            if (cfg_push) cfg_wr_ptr <= cfg_wr_ptr + 1'b1;
            if (cfg_pop)  cfg_rd_ptr <= cfg_rd_ptr + 1'b1;
        end
    end

    // ---------------- AXI beat buffer ----------------
    logic [AXI_DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
    logic [BUF_AWIDTH:0]       buf_wr_ptr, buf_rd_ptr;
    logic                      buf_empty, buf_full, buf_push, beat_pop;
    logic [AXI_DATA_WIDTH-1:0] buf_head;

    assign buf_empty  = (buf_wr_ptr == buf_rd_ptr);
    assign buf_full   = (buf_wr_ptr[BUF_AWIDTH] != buf_rd_ptr[BUF_AWIDTH]) &&
                        (buf_wr_ptr[BUF_AWIDTH-1:0] == buf_rd_ptr[BUF_AWIDTH-1:0]);
    assign axi_rready = ~buf_full;
    assign buf_push   = axi_rvalid & ~buf_full;
    assign buf_head   = buf_mem[buf_rd_ptr[BUF_AWIDTH-1:0]];

    // Store accepted AXI beats.
    always_ff @(posedge clk) begin
        if (buf_push)
            buf_mem[buf_wr_ptr[BUF_AWIDTH-1:0]] <= axi_rdata;
    end

    // Beat buffer pointers; a pop only frees its slot from the next cycle on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_wr_ptr <= '0;
            buf_rd_ptr <= '0;
        end else begin
            if (buf_push) buf_wr_ptr <= buf_wr_ptr + 1'b1;
            if (beat_pop) buf_rd_ptr <= buf_rd_ptr + 1'b1;
        end
    end

    // ---------------- word selection ----------------
    logic [DATA_WIDTH-1:0] beat_words [R];
    for (genvar g = 0; g < R; g++) begin : g_split
        assign beat_words[g] = buf_head[g*DATA_WIDTH +: DATA_WIDTH];
    end

    logic [CFG_DWIDTH-1:0] cfg_q, len_m1, cnt;
    logic [SUB_W-1:0]      sub;
    logic                  word_is_last, word_load, chain;

    assign word_is_last = (cnt == len_m1);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_CONFIG;
        else     state <= state_nxt;
    end

    // Next state and per-cycle controls. Words are fetched into the output
    // register one ahead of the handshake; when the final word of a stream is
    // fetched and a non-zero length is already queued, the next stream is
    // started directly so back-to-back streams run without a bubble.
    always_comb begin
        state_nxt = state;
        cfg_pop   = 1'b0;
        word_load = 1'b0;
        beat_pop  = 1'b0;
        chain     = 1'b0;
        case (state)
            ST_CONFIG: begin
                if (!cfg_empty) begin
                    cfg_pop   = 1'b1;
                    state_nxt = ST_SET;
                end
            end
            ST_SET: begin
                state_nxt = (cfg_q == '0) ? ST_CONFIG : ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (!buf_empty && (!valid || ready)) begin
                    word_load = 1'b1;
                    beat_pop  = (sub == SUB_LAST) || word_is_last;
                    if (word_is_last) begin
                        if (!cfg_empty && (cfg_head != '0)) begin
                            cfg_pop = 1'b1;
                            chain   = 1'b1;
                        end else begin
                            state_nxt = ST_CONFIG;
                        end
                    end
                end
            end
            default: state_nxt = ST_CONFIG;
        endcase
    end

    // Stream length, word counter and sub-word index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_q  <= '0;
            len_m1 <= '0;
            cnt    <= '0;
            sub    <= '0;
        end else begin
            if (cfg_pop) cfg_q <= cfg_head;
            if (state == ST_SET) begin
                len_m1 <= cfg_q - CFG_DWIDTH'(1);
                cnt    <= '0;
                sub    <= '0;
            end else if (word_load) begin
                if (chain) begin
                    len_m1 <= cfg_head - CFG_DWIDTH'(1);
                    cnt    <= '0;
                    sub    <= '0;
                end else begin
                    cnt <= cnt + CFG_DWIDTH'(1);
                    sub <= (sub == SUB_LAST) ? '0 : sub + 1'b1;
                end
            end
        end
    end

    // Output stage: holds one word, stable while valid and not ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
            last  <= 1'b0;
        end else if (word_load) begin
            data  <= beat_words[sub];
            valid <= 1'b1;
            last  <= word_is_last;
        end else if (ready) begin
            valid <= 1'b0;
            last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_read_data.sv
// Directed testbench for axis_read_data (R = 2: 64-bit beats, 32-bit words).
module tb_axis_read_data;

    logic        clk;
    logic        rst;
    logic [31:0] cfg_length;
    logic        cfg_val;
    logic        cfg_rdy;
    logic [63:0] axi_rdata;
    logic        axi_rlast;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [31:0] data;
    logic        valid;
    logic        last;
    logic        ready;

    int total = 0;
    int bad   = 0;

    axis_read_data #(
        .BUF_CFG_AWIDTH(5),
        .BUF_AWIDTH    (9),
        .CFG_DWIDTH    (32),
        .AXI_DATA_WIDTH(64),
        .DATA_WIDTH    (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_length(cfg_length),
        .cfg_val   (cfg_val),
        .cfg_rdy   (cfg_rdy),
        .axi_rdata (axi_rdata),
        .axi_rlast (axi_rlast),
        .axi_rvalid(axi_rvalid),
        .axi_rready(axi_rready),
        .data      (data),
        .valid     (valid),
        .last      (last),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // All tasks are entered at a falling edge and return at a falling edge.
    task automatic push_cfg(input logic [31:0] len);
        cfg_length = len;
        cfg_val    = 1'b1;
        @(negedge clk);
        cfg_val    = 1'b0;
    endtask

    task automatic push_beat(input logic [31:0] hi, input logic [31:0] lo);
        int k;
        k = 0;
        axi_rdata  = {hi, lo};
        axi_rvalid = 1'b1;
        while (!axi_rready && k < 600) begin
            @(negedge clk);
            k++;
        end
        chk("beat_accept", axi_rready, 1'b1);
        @(negedge clk);
        axi_rvalid = 1'b0;
    endtask

    // Expects ready=1; waits (bounded) for a word, checks it, lets it transfer.
    task automatic get_word(input string tag, input logic [31:0] exp_d,
                            input logic exp_l, output int waited);
        int k;
        k = 0;
        while (!valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        waited = k;
        chk({tag, "_valid"}, valid, 1'b1);
        chk({tag, "_data"}, data, exp_d);
        chk({tag, "_last"}, last, exp_l);
        @(negedge clk);
    endtask

    initial begin
        int w, gaps, lat, idx, lasts, acc;
        rst        = 1'b1;
        cfg_length = '0;
        cfg_val    = 1'b0;
        axi_rdata  = '0;
        axi_rlast  = 1'b0;
        axi_rvalid = 1'b0;
        ready      = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", valid, 1'b0);
        chk("rst_last", last, 1'b0);
        chk("rst_data", data, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cfg_rdy", cfg_rdy, 1'b1);
        chk("rst_axi_rready", axi_rready, 1'b1);

        // Single stream of 8 words, plus config-to-valid latency
        for (int i = 0; i < 4; i++) push_beat(2*i + 1, 2*i);
        push_cfg(8);
        lat = 0;
        while (!valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("t1_latency_ok", (lat <= 3), 1'b1);
        ready = 1'b1;
        gaps  = 0;
        for (int i = 0; i < 8; i++) begin
            get_word("t1", i, (i == 7), w);
            gaps += w;
        end
        chk("t1_gaps", gaps, 0);
        chk("t1_idle", valid, 1'b0);

        // Odd length followed by a second stream, no gap between them
        ready = 1'b0;
        push_cfg(3);
        push_cfg(2);
        push_beat(32'hB, 32'hA);
        push_beat(32'hD, 32'hC);
        push_beat(32'hF, 32'hE);
        repeat (3) @(negedge clk);
        ready = 1'b1;
        gaps  = 0;
        get_word("t2_a", 32'hA, 1'b0, w); gaps += w;
        get_word("t2_b", 32'hB, 1'b0, w); gaps += w;
        get_word("t2_c", 32'hC, 1'b1, w); gaps += w;
        get_word("t2_e", 32'hE, 1'b0, w); gaps += w;
        get_word("t2_f", 32'hF, 1'b1, w); gaps += w;
        chk("t2_gaps", gaps, 0);
        chk("t2_idle", valid, 1'b0);

        // Backpressure: ready toggles 1,0,1,0...
        ready = 1'b0;
        push_cfg(16);
        for (int i = 0; i < 8; i++) push_beat(32'h100 + 2*i + 1, 32'h100 + 2*i);
        repeat (3) @(negedge clk);
        idx   = 0;
        lasts = 0;
        for (int c = 0; c < 60 && idx < 16; c++) begin
            ready = (c % 2 == 0);
            if (valid) begin
                chk("t3_data", data, 32'h100 + idx);
                if (ready) begin
                    chk("t3_last", last, (idx == 15));
                    if (last) lasts++;
                    idx++;
                end
            end
            @(negedge clk);
        end
        chk("t3_count", idx, 16);
        chk("t3_lasts", lasts, 1);
        chk("t3_idle", valid, 1'b0);

        // Zero length: no output, no beat consumed
        ready = 1'b1;
        push_beat(32'h31, 32'h30);
        push_cfg(0);
        repeat (5) @(negedge clk);
        chk("t4_zero_idle", valid, 1'b0);
        push_cfg(2);
        get_word("t4_w0", 32'h30, 1'b0, w);
        get_word("t4_w1", 32'h31, 1'b1, w);
        repeat (3) @(negedge clk);
        chk("t4_idle", valid, 1'b0);

        // Full buffer: 516 beats offered while stalled, 512 accepted
        ready = 1'b0;
        push_cfg(1024);
        acc = 0;
        for (int i = 0; i < 516; i++) begin
            axi_rdata  = {32'h1000 + 32'(2*acc + 1), 32'h1000 + 32'(2*acc)};
            axi_rvalid = 1'b1;
            if (axi_rready) acc++;
            @(negedge clk);
        end
        axi_rvalid = 1'b0;
        chk("t5_accepted", acc, 512);
        chk("t5_full_rready", axi_rready, 1'b0);
        ready = 1'b1;
        gaps  = 0;
        for (int k = 0; k < 1024; k++) begin
            get_word("t5", 32'h1000 + k, (k == 1023), w);
            gaps += w;
        end
        chk("t5_gaps", gaps, 0);
        chk("t5_idle", valid, 1'b0);
        chk("t5_rready_back", axi_rready, 1'b1);

        // Reset mid-stream after 5 of 8 words
        ready = 1'b0;
        push_cfg(8);
        for (int i = 0; i < 4; i++) push_beat(32'h200 + 2*i + 1, 32'h200 + 2*i);
        repeat (3) @(negedge clk);
        ready = 1'b1;
        for (int i = 0; i < 5; i++) get_word("t6_old", 32'h200 + i, 1'b0, w);
        chk("t6_pre_valid", valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", valid, 1'b0);
        chk("t6_rst_last", last, 1'b0);
        chk("t6_rst_data", data, 32'h0);
        chk("t6_rst_cfg_rdy", cfg_rdy, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rel_rready", axi_rready, 1'b1);
        chk("t6_rel_idle", valid, 1'b0);
        push_cfg(2);
        push_beat(32'h301, 32'h300);
        get_word("t6_new0", 32'h300, 1'b0, w);
        get_word("t6_new1", 32'h301, 1'b1, w);
        repeat (3) @(negedge clk);
        chk("t6_idle", valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
